// File: rtl/pulp_cluster_package.sv
// Shared constants and request payload type for the speriph round-robin arbiter.
// The id field is sized for the widest supported id; narrower ids are zero-extended.
package pulp_cluster_package;

  localparam int SPER_ARB_MAX_OUTSTANDING = 2;
  localparam int SPER_ARB_ID_MAX_WIDTH    = 16;

  typedef struct packed {
    logic [31:0]                      add;
    logic                             wen;
    logic [31:0]                      wdata;
    logic [3:0]                       be;
    logic [SPER_ARB_ID_MAX_WIDTH-1:0] id;
  } speriph_req_t;

endpackage

// File: rtl/speriph_arb_rsp_fifo.sv
// In-order FIFO of granted plug indices, used to route each slave response back to its issuer.
// Pointers carry one extra wrap bit so that full and empty are told apart by the pointer difference.
module speriph_arb_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  // A single-entry FIFO still gets a 1-bit address so the pointer arithmetic stays uniform.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      used;

  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == (AW+1)'(DEPTH));
  assign empty = (used == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/speriph_plug_rr_arbiter.sv
// Round-robin arbiter sharing one speriph slave among NB_PLUGS interconnect plugs.
// Optional build macro SPERIPH_ARB_STATS_EN adds conflict_cnt_o and unexp_rsp_o.
module speriph_plug_rr_arbiter
  import pulp_cluster_package::*;
#(
  parameter int NB_PLUGS        = 2,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = SPER_ARB_MAX_OUTSTANDING
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_PLUGS-1:0]          plug_req_i,
  input  logic [NB_PLUGS*32-1:0]       plug_add_i,
  input  logic [NB_PLUGS-1:0]          plug_wen_i,
  input  logic [NB_PLUGS*32-1:0]       plug_wdata_i,
  input  logic [NB_PLUGS*4-1:0]        plug_be_i,
  input  logic [NB_PLUGS*ID_WIDTH-1:0] plug_id_i,
  output logic [NB_PLUGS-1:0]          plug_gnt_o,
  output logic [NB_PLUGS-1:0]          plug_r_valid_o,
  output logic [31:0]                  plug_r_rdata_o,
  output logic                         plug_r_opc_o,
  output logic [ID_WIDTH-1:0]          plug_r_id_o,
  output logic                         slv_req_o,
  output logic [31:0]                  slv_add_o,
  output logic                         slv_wen_o,
  output logic [31:0]                  slv_wdata_o,
  output logic [3:0]                   slv_be_o,
  output logic [ID_WIDTH-1:0]          slv_id_o,
  input  logic                         slv_gnt_i,
  input  logic                         slv_r_valid_i,
  input  logic [31:0]                  slv_r_rdata_i,
  input  logic                         slv_r_opc_i,
  input  logic [ID_WIDTH-1:0]          slv_r_id_i
`ifdef SPERIPH_ARB_STATS_EN
  ,output logic [15:0]                 conflict_cnt_o
  ,output logic                        unexp_rsp_o
`endif
);

  localparam int IDX_W = $clog2(NB_PLUGS);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             hs;
  logic             pop;
  speriph_req_t     plug_pld [NB_PLUGS];
  speriph_req_t     sel;
  logic             unused_id;

  // Modulo-NB_PLUGS add; both operands are below NB_PLUGS so one correction step suffices.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NB_PLUGS)) begin
      sum = sum - (IDX_W+1)'(NB_PLUGS);
    end
    return sum[IDX_W-1:0];
  endfunction

  for (genvar p = 0; p < NB_PLUGS; p++) begin : g_pld
    assign plug_pld[p] = '{
      add:   plug_add_i[p*32 +: 32],
      wen:   plug_wen_i[p],
      wdata: plug_wdata_i[p*32 +: 32],
      be:    plug_be_i[p*4 +: 4],
      id:    SPER_ARB_ID_MAX_WIDTH'(plug_id_i[p*ID_WIDTH +: ID_WIDTH])
    };
  end

  // First requesting plug at or after rr_q; with no requests the pointer itself is selected.
  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      cand = wrap_add(rr_q, IDX_W'(i));
      if (!found && plug_req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel       = plug_pld[winner];
  assign unused_id = ^sel.id;

  assign slv_req_o   = (|plug_req_i) & ~fifo_full & ~rst_i;
  assign slv_add_o   = sel.add;
  assign slv_wen_o   = sel.wen;
  assign slv_wdata_o = sel.wdata;
  assign slv_be_o    = sel.be;
  assign slv_id_o    = sel.id[ID_WIDTH-1:0];

  assign hs  = slv_req_o & slv_gnt_i;
  assign pop = slv_r_valid_i & ~fifo_empty & ~rst_i;

  assign plug_r_rdata_o = slv_r_rdata_i;
  assign plug_r_opc_o   = slv_r_opc_i;
  assign plug_r_id_o    = slv_r_id_i;

  always_comb begin
    plug_gnt_o     = '0;
    plug_r_valid_o = '0;
    if (hs) begin
      plug_gnt_o[winner] = 1'b1;
    end
    if (pop) begin
      plug_r_valid_o[head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (hs) begin
      rr_q <= wrap_add(winner, IDX_W'(1));
    end
  end

  speriph_arb_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) i_rsp_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (hs),
    .push_data (winner),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SPERIPH_ARB_STATS_EN
  logic multi_req;

  assign multi_req = (plug_req_i & (plug_req_i - NB_PLUGS'(1))) != '0;

  // Conflict cycles saturate; the unexpected-response flag stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
      unexp_rsp_o    <= 1'b0;
    end else begin
      if (hs && multi_req && (conflict_cnt_o != 16'hFFFF)) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
      if (slv_r_valid_i && fifo_empty) begin
        unexp_rsp_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_speriph_plug_rr_arbiter.sv
// Self-checking bench for speriph_plug_rr_arbiter: queue-based reference model plus directed and random traffic.
// Build with SPERIPH_ARB_STATS_EN defined to also check the statistics outputs.
module tb_speriph_plug_rr_arbiter;

  localparam int NB   = 2;
  localparam int IDW  = 5;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NB-1:0]        plug_req;
  logic [NB*32-1:0]     plug_add;
  logic [NB-1:0]        plug_wen;
  logic [NB*32-1:0]     plug_wdata;
  logic [NB*4-1:0]      plug_be;
  logic [NB*IDW-1:0]    plug_id;
  logic [NB-1:0]        plug_gnt;
  logic [NB-1:0]        plug_r_valid;
  logic [31:0]          plug_r_rdata;
  logic                 plug_r_opc;
  logic [IDW-1:0]       plug_r_id;
  logic                 slv_req;
  logic [31:0]          slv_add;
  logic                 slv_wen;
  logic [31:0]          slv_wdata;
  logic [3:0]           slv_be;
  logic [IDW-1:0]       slv_id;
  logic                 slv_gnt;
  logic                 slv_r_valid;
  logic [31:0]          slv_r_rdata;
  logic                 slv_r_opc;
  logic [IDW-1:0]       slv_r_id;
`ifdef SPERIPH_ARB_STATS_EN
  logic [15:0]          conflict_cnt;
  logic                 unexp_rsp;
`endif

  speriph_plug_rr_arbiter #(
    .NB_PLUGS        (NB),
    .ID_WIDTH        (IDW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .plug_req_i     (plug_req),
    .plug_add_i     (plug_add),
    .plug_wen_i     (plug_wen),
    .plug_wdata_i   (plug_wdata),
    .plug_be_i      (plug_be),
    .plug_id_i      (plug_id),
    .plug_gnt_o     (plug_gnt),
    .plug_r_valid_o (plug_r_valid),
    .plug_r_rdata_o (plug_r_rdata),
    .plug_r_opc_o   (plug_r_opc),
    .plug_r_id_o    (plug_r_id),
    .slv_req_o      (slv_req),
    .slv_add_o      (slv_add),
    .slv_wen_o      (slv_wen),
    .slv_wdata_o    (slv_wdata),
    .slv_be_o       (slv_be),
    .slv_id_o       (slv_id),
    .slv_gnt_i      (slv_gnt),
    .slv_r_valid_i  (slv_r_valid),
    .slv_r_rdata_i  (slv_r_rdata),
    .slv_r_opc_i    (slv_r_opc),
    .slv_r_id_i     (slv_r_id)
`ifdef SPERIPH_ARB_STATS_EN
    ,.conflict_cnt_o (conflict_cnt)
    ,.unexp_rsp_o    (unexp_rsp)
`endif
  );

  logic [31:0]    pl_add   [NB];
  logic           pl_wen   [NB];
  logic [31:0]    pl_wdata [NB];
  logic [3:0]     pl_be    [NB];
  logic [IDW-1:0] pl_id    [NB];
  logic [31:0]    rsp_rdata;
  logic           rsp_opc;
  logic [IDW-1:0] rsp_id;

  int             n_vec;
  int             n_err;
  int             rr;
  int             mq[$];
  logic [IDW-1:0] slv_q[$];
  logic [NB-1:0]  last_gnt;
  logic [NB-1:0]  act;
  int             exp_cnt;
  logic           exp_unexp;

  task automatic cmp(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Model: arbitration pointer plus a queue of issuing plugs, advanced once per cycle.
  task automatic checkOutput();
    logic          ereq;
    logic          hs;
    logic          pop;
    logic [NB-1:0] eg;
    logic [NB-1:0] ev;
    int            win;
    win  = -1;
    for (int i = 0; i < NB; i++) begin
      if (win < 0 && plug_req[(rr + i) % NB]) win = (rr + i) % NB;
    end
    ereq = !rst && (plug_req != '0) && (mq.size() < MAXO);
    hs   = ereq && slv_gnt;
    pop  = !rst && slv_r_valid && (mq.size() > 0);
    eg   = '0;
    ev   = '0;
    if (hs) eg[win] = 1'b1;
    if (pop) ev[mq[0]] = 1'b1;
    cmp("slv_req", slv_req, ereq);
    cmp("plug_gnt", plug_gnt, eg);
    cmp("plug_r_valid", plug_r_valid, ev);
    if (ereq) begin
      cmp("slv_add", slv_add, pl_add[win]);
      cmp("slv_wen", slv_wen, pl_wen[win]);
      cmp("slv_wdata", slv_wdata, pl_wdata[win]);
      cmp("slv_be", slv_be, pl_be[win]);
      cmp("slv_id", slv_id, pl_id[win]);
    end
    if (pop) begin
      cmp("r_rdata", plug_r_rdata, rsp_rdata);
      cmp("r_opc", plug_r_opc, rsp_opc);
      cmp("r_id", plug_r_id, rsp_id);
    end
`ifdef SPERIPH_ARB_STATS_EN
    cmp("conflict_cnt", conflict_cnt, exp_cnt);
    cmp("unexp_rsp", unexp_rsp, exp_unexp);
`endif
    if (rst) begin
      rr = 0;
      mq.delete();
      exp_cnt   = 0;
      exp_unexp = 1'b0;
    end else begin
      if (slv_r_valid && mq.size() == 0) exp_unexp = 1'b1;
      if (pop) void'(mq.pop_front());
      if (hs) begin
        mq.push_back(win);
        rr = (win + 1) % NB;
        if ($countones(plug_req) >= 2 && exp_cnt < 65535) exp_cnt++;
      end
    end
    last_gnt = eg;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] r, input logic g, input logic rv, input logic rs);
    @(negedge clk);
    rst         = rs;
    plug_req    = r;
    slv_gnt     = g;
    slv_r_valid = rv;
    for (int p = 0; p < NB; p++) begin
      plug_add[p*32 +: 32]   = pl_add[p];
      plug_wen[p]            = pl_wen[p];
      plug_wdata[p*32 +: 32] = pl_wdata[p];
      plug_be[p*4 +: 4]      = pl_be[p];
      plug_id[p*IDW +: IDW]  = pl_id[p];
    end
    slv_r_rdata = rsp_rdata;
    slv_r_opc   = rsp_opc;
    slv_r_id    = rsp_id;
    #2;
    checkOutput();
  endtask

  initial begin
    n_vec = 0; n_err = 0; rr = 0; last_gnt = '0; exp_cnt = 0; exp_unexp = 1'b0;
    rst = 1'b1; plug_req = '0; plug_add = '0; plug_wen = '0; plug_wdata = '0;
    plug_be = '0; plug_id = '0; slv_gnt = 1'b0; slv_r_valid = 1'b0;
    slv_r_rdata = '0; slv_r_opc = 1'b0; slv_r_id = '0;
    pl_add[0] = 32'h1000_0000; pl_add[1] = 32'h1000_0004;
    pl_wen[0] = 1'b1;          pl_wen[1] = 1'b0;
    pl_wdata[0] = 32'hAAAA_0000; pl_wdata[1] = 32'h5555_1111;
    pl_be[0] = 4'hF;           pl_be[1] = 4'h3;
    pl_id[0] = 5'h0A;          pl_id[1] = 5'h15;
    rsp_rdata = 32'hDEAD_BEEF; rsp_opc = 1'b0; rsp_id = '0;

    $display("[TB] reset");
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
    cmp("rst_slv_req", slv_req, 1'b0);
    cmp("rst_gnt", plug_gnt, 2'b00);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);

    $display("[TB] alternating grants with 1-cycle responses");
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    cmp("t1_gnt_a", plug_gnt, 2'b01);
    cmp("t1_rv_a", plug_r_valid, 2'b00);
    rsp_id = 5'h0A;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    cmp("t1_gnt_b", plug_gnt, 2'b10);
    cmp("t1_rv_b", plug_r_valid, 2'b01);
    cmp("t1_rid_b", plug_r_id, 5'h0A);
    rsp_id = 5'h15;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    cmp("t1_gnt_c", plug_gnt, 2'b01);
    cmp("t1_rv_c", plug_r_valid, 2'b10);
    rsp_id = 5'h0A;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    cmp("t1_gnt_d", plug_gnt, 2'b10);
    cmp("t1_rv_d", plug_r_valid, 2'b01);
    rsp_id = 5'h15;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    cmp("t1_rv_e", plug_r_valid, 2'b10);

    $display("[TB] single requester back-to-back");
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0);
    cmp("t2_gnt_0", plug_gnt, 2'b10);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 1'b1, 1'b1, 1'b0);
      cmp("t2_gnt_n", plug_gnt, 2'b10);
      cmp("t2_rv_n", plug_r_valid, 2'b10);
    end
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    cmp("t2_rv_last", plug_r_valid, 2'b10);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    cmp("t2_rr_wrap_add", slv_add, 32'h1000_0000);

    $display("[TB] stalled winner held");
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    cmp("t4_setup_gnt", plug_gnt, 2'b01);
    rsp_id = 5'h0A;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
      cmp("t4_stall_gnt", plug_gnt, 2'b00);
      cmp("t4_stall_add", slv_add, 32'h1000_0004);
      cmp("t4_stall_wdata", slv_wdata, 32'h5555_1111);
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    cmp("t4_gnt", plug_gnt, 2'b10);
    rsp_id = 5'h15;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);

    $display("[TB] response with empty FIFO");
    rsp_id = 5'h1F;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    cmp("t5_rv", plug_r_valid, 2'b00);

    $display("[TB] FIFO full back-pressure");
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    cmp("t3_gnt_a", plug_gnt, 2'b01);
`ifdef SPERIPH_ARB_STATS_EN
    cmp("t5_unexp", unexp_rsp, 1'b1);
`endif
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    cmp("t3_gnt_b", plug_gnt, 2'b10);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      cmp("t3_full_req", slv_req, 1'b0);
    end
    rsp_id = 5'h0A;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    cmp("t3_pop_req", slv_req, 1'b0);
    cmp("t3_pop_rv", plug_r_valid, 2'b01);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    cmp("t3_regnt", plug_gnt, 2'b01);

    $display("[TB] reset with outstanding transactions");
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    cmp("t6_rst_req", slv_req, 1'b0);
`ifdef SPERIPH_ARB_STATS_EN
    cmp("t6_conflicts", conflict_cnt, 16'd8);
`endif
    rsp_id = 5'h15;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    cmp("t6_late_rv_a", plug_r_valid, 2'b00);
    rsp_id = 5'h0A;
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
    cmp("t6_late_rv_b", plug_r_valid, 2'b00);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    cmp("t6_rr_reset", slv_add, 32'h1000_0000);

    $display("[TB] random traffic");
    act = '1;
    slv_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic g;
      logic rv;
      logic rs;
      for (int p = 0; p < NB; p++) begin
        if (last_gnt[p]) act[p] = 1'b0;
        if (!act[p] && $urandom_range(0, 2) == 0) begin
          act[p]      = 1'b1;
          pl_add[p]   = $urandom;
          pl_wen[p]   = 1'($urandom);
          pl_wdata[p] = $urandom;
          pl_be[p]    = 4'($urandom);
          pl_id[p]    = IDW'($urandom);
        end
      end
      g  = ($urandom_range(0, 3) != 0);
      rv = 1'b0;
      if (slv_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv     = 1'b1;
        rsp_id = slv_q.pop_front();
      end else if ($urandom_range(0, 24) == 0) begin
        rv     = 1'b1;
        rsp_id = IDW'($urandom);
      end
      rsp_rdata = $urandom;
      rsp_opc   = 1'($urandom);
      rs        = ($urandom_range(0, 199) == 0);
      applyStimulus(act, g, rv, rs);
      for (int p = 0; p < NB; p++) begin
        if (last_gnt[p]) slv_q.push_back(pl_id[p]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
